// File: rtl/ascon_bdi_packer_pkg.sv
// Shared Ascon datapath configuration: core word width and segment type codes.
package ascon_bdi_packer_pkg;

    localparam int CCW   = 32;
    localparam int CCWD8 = CCW / 8;

    localparam logic [3:0] D_NULL  = 4'h0;
    localparam logic [3:0] D_NONCE = 4'h1;
    localparam logic [3:0] D_AD    = 4'h2;
    localparam logic [3:0] D_MSG   = 4'h4;
    localparam logic [3:0] D_TAG   = 4'h8;

endpackage

// File: rtl/ascon_bdi_packer.sv
// Packs a byte stream into CCW-bit words for the Ascon core, one cycle from the completing byte to bdi.
// Input stalls only while a finished word waits for a busy output register, or for one flush cycle on a type change.
module ascon_bdi_packer #(
    parameter int CCW = ascon_bdi_packer_pkg::CCW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [3:0]           s_type,
    input  logic                 s_eot,
    input  logic                 s_eoi,
    input  logic                 s_empty,
    output logic [CCW-1:0]       bdi,
    output logic [CCW/8-1:0]     bdi_valid,
    input  logic                 bdi_ready,
    output logic [3:0]           bdi_type,
    output logic                 bdi_eot,
    output logic                 bdi_eoi
);
    import ascon_bdi_packer_pkg::*;

    localparam int CCWD8 = CCW / 8;
    localparam int CW    = $clog2(CCWD8 + 1);

    typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_STALL} state_t;

    state_t           r_state;
    logic [CCW-1:0]   r_a_data, r_o_data, w_n_data;
    logic [CW-1:0]    r_a_cnt, w_n_cnt;
    logic [3:0]       r_a_type, r_o_type, w_n_type;
    logic             r_a_eot, r_a_eoi, w_n_eot, w_n_eoi;
    logic             r_o_eot, r_o_eoi;
    logic [CCWD8-1:0] r_o_mask;
    logic             r_eoi_pend;
    logic             w_o_free, w_type_mis, w_acc, w_done;

    function automatic logic [CCWD8-1:0] fill_mask(input logic [CW-1:0] cnt);
        fill_mask = '0;
        for (int k = 0; k < CCWD8; k++) fill_mask[k] = (CW'(k) < cnt);
    endfunction

    assign w_o_free   = (r_o_mask == '0) || bdi_ready;
    // A data beat of a new type must wait one cycle while the partial word is pushed out.
    assign w_type_mis = s_valid && !s_empty && (r_state == ST_FILL) && (s_type != r_a_type);
    assign s_ready    = !rst && (r_state != ST_STALL) && !w_type_mis;
    assign w_acc      = s_valid && s_ready;

    always_comb begin
        w_n_data = r_a_data;
        w_n_cnt  = r_a_cnt;
        w_n_type = r_a_type;
        w_n_eot  = r_a_eot;
        w_n_eoi  = r_a_eoi;
        w_done   = 1'b0;
        if (r_state == ST_STALL || w_type_mis) begin
            w_done = 1'b1;
        end else if (w_acc && !s_empty) begin
            for (int k = 0; k < CCWD8; k++) begin
                if (CW'(k) == r_a_cnt) w_n_data[8*k +: 8] = s_data;
            end
            w_n_cnt  = r_a_cnt + 1'b1;
            w_n_type = s_type;
            w_n_eot  = s_eot;
            w_n_eoi  = s_eoi;
            w_done   = (w_n_cnt == CW'(CCWD8)) || s_eot || s_eoi;
        end else if (w_acc && (r_a_cnt != '0) && (s_eot || s_eoi)) begin
            w_n_eot = r_a_eot | s_eot;
            w_n_eoi = r_a_eoi | s_eoi;
            w_done  = 1'b1;
        end
    end

    assign bdi       = r_o_data;
    assign bdi_valid = r_o_mask;
    assign bdi_type  = r_o_type;
    assign bdi_eot   = r_o_eot;
    assign bdi_eoi   = (r_o_mask != '0) ? r_o_eoi : r_eoi_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_a_data   <= '0;
            r_a_cnt    <= '0;
            r_a_type   <= D_NULL;
            r_a_eot    <= 1'b0;
            r_a_eoi    <= 1'b0;
            r_o_data   <= '0;
            r_o_mask   <= '0;
            r_o_type   <= D_NULL;
            r_o_eot    <= 1'b0;
            r_o_eoi    <= 1'b0;
            r_eoi_pend <= 1'b0;
        end else begin
            if (w_done && w_o_free) begin
                r_o_data <= w_n_data;
                r_o_mask <= fill_mask(w_n_cnt);
                r_o_type <= w_n_type;
                r_o_eot  <= w_n_eot;
                r_o_eoi  <= w_n_eoi;
                r_a_data <= '0;
                r_a_cnt  <= '0;
                r_a_type <= D_NULL;
                r_a_eot  <= 1'b0;
                r_a_eoi  <= 1'b0;
                r_state  <= ST_EMPTY;
            end else begin
                r_a_data <= w_n_data;
                r_a_cnt  <= w_n_cnt;
                r_a_type <= w_n_type;
                r_a_eot  <= w_n_eot;
                r_a_eoi  <= w_n_eoi;
                r_state  <= w_done ? ST_STALL : ((w_n_cnt != '0) ? ST_FILL : ST_EMPTY);
                if (bdi_ready) begin
                    r_o_data <= '0;
                    r_o_mask <= '0;
                    r_o_type <= D_NULL;
                    r_o_eot  <= 1'b0;
                    r_o_eoi  <= 1'b0;
                end
            end
            // A bare end-of-input marker is held until real data follows.
            if (w_acc && !s_empty)
                r_eoi_pend <= 1'b0;
            else if (w_acc && s_empty && s_eoi && (r_a_cnt == '0))
                r_eoi_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ascon_bdi_packer.sv
// Directed-vector bench for ascon_bdi_packer at CCW=32.
module tb_ascon_bdi_packer;
    import ascon_bdi_packer_pkg::*;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  m;
        logic [3:0]  t;
        logic        eot;
        logic        eoi;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid, s_ready, s_eot, s_eoi, s_empty;
    logic [3:0]  s_type;
    logic [31:0] bdi;
    logic [CCWD8-1:0] bdi_valid;
    logic        bdi_ready;
    logic [3:0]  bdi_type;
    logic        bdi_eot, bdi_eoi;

    int    checks   = 0;
    int    failures = 0;
    int    n_acc    = 0;
    word_t got_q[$];
    word_t exp_q[$];

    ascon_bdi_packer dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_type    (s_type),
        .s_eot     (s_eot),
        .s_eoi     (s_eoi),
        .s_empty   (s_empty),
        .bdi       (bdi),
        .bdi_valid (bdi_valid),
        .bdi_ready (bdi_ready),
        .bdi_type  (bdi_type),
        .bdi_eot   (bdi_eot),
        .bdi_eoi   (bdi_eoi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic word_t mk(input logic [31:0] d, input logic [3:0] m, input logic [3:0] t,
                                 input logic eot, input logic eoi);
        word_t w;
        w.d = d; w.m = m; w.t = t; w.eot = eot; w.eoi = eoi;
        return w;
    endfunction

    // Words are captured mid-cycle, where the values seen are those the next rising edge samples.
    always @(negedge clk) begin
        if (!rst) begin
            if (bdi_valid != '0 && bdi_ready)
                got_q.push_back(mk(bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi));
            if (s_valid && s_ready) n_acc++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [3:0] t, input logic [7:0] d, input logic eot, input logic eoi,
                        input logic emp, output int ncyc);
        logic acc;
        acc  = 1'b0;
        ncyc = 0;
        s_valid = 1'b1; s_type = t; s_data = d; s_eot = eot; s_eoi = eoi; s_empty = emp;
        while (!acc && ncyc < 50) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            ncyc++;
        end
        s_valid = 1'b0; s_data = 8'h00; s_eot = 1'b0; s_eoi = 1'b0; s_empty = 1'b0;
        chk("send_accepted", 64'(acc), 64'(1));
    endtask

    task automatic compare_words(input string tag);
        chk({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_type = D_NULL;
        s_eot = 1'b0; s_eoi = 1'b0; s_empty = 1'b0; bdi_ready = 1'b1;

        // Reset state
        idle(2);
        chk("rst_valid",   64'(bdi_valid), 64'(0));
        chk("rst_bdi",     64'(bdi),       64'(0));
        chk("rst_type",    64'(bdi_type),  64'(D_NULL));
        chk("rst_eot",     64'(bdi_eot),   64'(0));
        chk("rst_eoi",     64'(bdi_eoi),   64'(0));
        chk("rst_s_ready", 64'(s_ready),   64'(0));
        rst = 1'b0;
        idle(1);
        chk("post_rst_s_ready", 64'(s_ready), 64'(1));

        // Five AD bytes: a full word then a one-byte tail carrying eot
        for (int i = 1; i <= 5; i++) begin
            send(D_AD, 8'(i), (i == 5), 1'b0, 1'b0, n);
            if (i == 4) chk("t1_latency_mask", 64'(bdi_valid), 64'(4'hF));
        end
        exp_q.push_back(mk(32'h04030201, 4'b1111, D_AD, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h00000005, 4'b0001, D_AD, 1'b1, 1'b0));
        idle(3);
        compare_words("t1");

        // Twelve MSG bytes against a stalled core
        bdi_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                int n1;
                for (int i = 0; i < 12; i++) send(D_MSG, 8'h10 + 8'(i), (i == 11), 1'b0, 1'b0, n1);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("t2_hold_early", 64'(bdi), 64'(32'h13121110));
                repeat (4) @(posedge clk);
                #1;
                chk("t2_accepted",   64'(n_acc),     64'(8));
                chk("t2_s_ready",    64'(s_ready),   64'(0));
                chk("t2_hold_data",  64'(bdi),       64'(32'h13121110));
                chk("t2_hold_mask",  64'(bdi_valid), 64'(4'hF));
                bdi_ready = 1'b1;
            end
        join
        exp_q.push_back(mk(32'h13121110, 4'b1111, D_MSG, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h17161514, 4'b1111, D_MSG, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h1B1A1918, 4'b1111, D_MSG, 1'b1, 1'b0));
        idle(3);
        compare_words("t2");

        // Type change flushes the partial AD word
        send(D_AD,  8'hAA, 1'b0, 1'b0, 1'b0, n);
        send(D_AD,  8'hBB, 1'b0, 1'b0, 1'b0, n);
        send(D_MSG, 8'hCC, 1'b1, 1'b0, 1'b0, n);
        chk("t3_flush_cycles", 64'(n), 64'(2));
        exp_q.push_back(mk(32'h0000BBAA, 4'b0011, D_AD,  1'b0, 1'b0));
        exp_q.push_back(mk(32'h000000CC, 4'b0001, D_MSG, 1'b1, 1'b0));
        idle(3);
        compare_words("t3");

        // Exact-multiple segment with eot and eoi on the last byte
        for (int i = 0; i < 4; i++) send(D_TAG, 8'hD0 + 8'(i), (i == 3), (i == 3), 1'b0, n);
        exp_q.push_back(mk(32'hD3D2D1D0, 4'b1111, D_TAG, 1'b1, 1'b1));
        idle(5);
        compare_words("t4");
        chk("t4_eoi_after", 64'(bdi_eoi), 64'(0));

        // Empty beat with eoi while idle
        send(D_MSG, 8'h00, 1'b1, 1'b1, 1'b1, n);
        chk("t5_eoi_set",   64'(bdi_eoi),   64'(1));
        chk("t5_valid_set", 64'(bdi_valid), 64'(0));
        idle(4);
        chk("t5_eoi_held",  64'(bdi_eoi),   64'(1));
        send(D_NONCE, 8'h42, 1'b1, 1'b0, 1'b0, n);
        chk("t5_eoi_clear", 64'(bdi_eoi),   64'(0));
        chk("t5_valid_new", 64'(bdi_valid), 64'(4'b0001));
        exp_q.push_back(mk(32'h00000042, 4'b0001, D_NONCE, 1'b1, 1'b0));
        idle(3);
        compare_words("t5");

        // Reset in the middle of a segment
        for (int i = 0; i < 3; i++) send(D_AD, 8'h31 + 8'(i), 1'b0, 1'b0, 1'b0, n);
        rst = 1'b1;
        idle(1);
        chk("t6_rst_valid",   64'(bdi_valid), 64'(0));
        chk("t6_rst_s_ready", 64'(s_ready),   64'(0));
        rst = 1'b0;
        idle(3);
        chk("t6_no_partial",  64'(bdi_valid), 64'(0));
        send(D_MSG, 8'h77, 1'b0, 1'b0, 1'b0, n);
        send(D_MSG, 8'h88, 1'b1, 1'b0, 1'b0, n);
        exp_q.push_back(mk(32'h00008877, 4'b0011, D_MSG, 1'b1, 1'b0));
        idle(3);
        compare_words("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
